// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM burst loader.
// Holds the loader state encoding and the index-width helper.
package rom_loader_pkg;

   typedef enum logic [1:0] {LD_IDLE, LD_ISSUE, LD_DRAIN, LD_DONE} ld_state_t;

   // The index counters must hold 0..depth inclusive, so they never wrap inside a burst.
   function automatic int idx_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid-tag shift register that matches the ROM read latency.
// A read issued in cycle n produces a capture strobe in cycle n+LAT.
module rd_latency_pipe #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_i,
   output logic valid_o
);

   logic [LAT-1:0] pipe_q;

   // The cast drops the oldest tag, so LAT=1 needs no special case.
   always_ff @(posedge clk) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= LAT'({pipe_q, valid_i});
   end

   assign valid_o = pipe_q[LAT-1];

endmodule

// File: rtl/rom_burst_loader.sv
// Streams DEPTH words from a synchronous ROM, starting at BASE_ADDR, into a register array.
// Defining ROM_LOADER_CKSUM_EN adds the checksum_o port, a running sum of the burst.
module rom_burst_loader
   import rom_loader_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_W     = 6,
   parameter int BASE_ADDR  = 0,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [DATA_W-1:0] rom_q_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_rd_en_o,
   output logic              busy_o,
   output logic              done_o,
`ifdef ROM_LOADER_CKSUM_EN
   output logic [DATA_W-1:0] checksum_o,
`endif
   output logic [DATA_W-1:0] data_out_o [DEPTH]
);

   localparam int IW    = idx_w(DEPTH);
   localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [IW-1:0]     LAST_CNT = IW'(DEPTH);
   localparam logic [IW-1:0]     ONE      = IW'(1);

   if (DEPTH < 1) begin : g_bad_depth
      $error("rom_burst_loader: DEPTH must be >= 1");
   end
   if (RD_LATENCY < 1) begin : g_bad_latency
      $error("rom_burst_loader: RD_LATENCY must be >= 1");
   end
   if (BASE_ADDR + DEPTH > 2**ADDR_W) begin : g_bad_range
      $error("rom_burst_loader: BASE_ADDR+DEPTH exceeds the ROM address space");
   end

   ld_state_t         state_q;
   logic [IW-1:0]     issue_idx_q;
   logic [IW-1:0]     cap_idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_en_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic              cap_stb;
   logic              start_acc;

   assign start_acc = start_i && (state_q == LD_IDLE || state_q == LD_DONE);

   rd_latency_pipe #(.LAT(RD_LATENCY)) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .valid_i (rd_en_q),
      .valid_o (cap_stb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LD_IDLE;
         issue_idx_q <= '0;
         cap_idx_q   <= '0;
         addr_q      <= BASE;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else begin
         if (cap_stb) begin
            data_q[cap_idx_q[SEL_W-1:0]] <= rom_q_i;
            cap_idx_q                    <= cap_idx_q + ONE;
         end
         case (state_q)
            LD_IDLE, LD_DONE: begin
               // data_q is deliberately kept; a reload overwrites entries in place.
               if (start_acc) begin
                  state_q     <= LD_ISSUE;
                  addr_q      <= BASE;
                  rd_en_q     <= 1'b1;
                  issue_idx_q <= ONE;
                  cap_idx_q   <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
               end
            end
            LD_ISSUE: begin
               if (issue_idx_q == LAST_CNT) begin
                  state_q <= LD_DRAIN;
                  rd_en_q <= 1'b0;
               end else begin
                  addr_q      <= BASE + ADDR_W'(issue_idx_q);
                  issue_idx_q <= issue_idx_q + ONE;
               end
            end
            LD_DRAIN: begin
               if (cap_idx_q == LAST_CNT) begin
                  state_q <= LD_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

`ifdef ROM_LOADER_CKSUM_EN
   logic [DATA_W-1:0] cksum_q;

   always_ff @(posedge clk) begin
      if (reset || start_acc) cksum_q <= '0;
      else if (cap_stb)       cksum_q <= cksum_q + rom_q_i;
   end

   assign checksum_o = cksum_q;
`endif

   assign rom_addr_o  = addr_q;
   assign rom_rd_en_o = rd_en_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign data_out_o  = data_q;

endmodule

// File: tb/tb_rom_burst_loader.sv
// Directed-plus-random bench for rom_burst_loader with behavioural ROM models of latency 1 and 3.
// Expected words, sums and edge numbers come from the addressing and timing rules, not the DUT.
module tb_rom_burst_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start_a, start_b, start_c;
   logic [7:0] q_a, q_b, q_c;
   logic [5:0] addr_a, addr_b, addr_c;
   logic       rd_a, rd_b, rd_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [7:0] da [32];
   logic [7:0] db [8];
   logic [7:0] dc [4];
`ifdef ROM_LOADER_CKSUM_EN
   logic [7:0] ck_a, ck_b, ck_c;
`endif
   logic [7:0] rom_a [64];
   logic [7:0] rom_b [64];
   logic [7:0] rom_c [64];
   logic [7:0] pb [3];

   int tests_run    = 0;
   int tests_failed = 0;

   rom_burst_loader u_a (
      .clk(clk), .reset(reset), .start_i(start_a), .rom_q_i(q_a), .rom_addr_o(addr_a),
      .rom_rd_en_o(rd_a), .busy_o(busy_a), .done_o(done_a),
`ifdef ROM_LOADER_CKSUM_EN
      .checksum_o(ck_a),
`endif
      .data_out_o(da));

   rom_burst_loader #(.DEPTH(8), .RD_LATENCY(3), .BASE_ADDR(16)) u_b (
      .clk(clk), .reset(reset), .start_i(start_b), .rom_q_i(q_b), .rom_addr_o(addr_b),
      .rom_rd_en_o(rd_b), .busy_o(busy_b), .done_o(done_b),
`ifdef ROM_LOADER_CKSUM_EN
      .checksum_o(ck_b),
`endif
      .data_out_o(db));

   rom_burst_loader #(.DEPTH(4)) u_c (
      .clk(clk), .reset(reset), .start_i(start_c), .rom_q_i(q_c), .rom_addr_o(addr_c),
      .rom_rd_en_o(rd_c), .busy_o(busy_c), .done_o(done_c),
`ifdef ROM_LOADER_CKSUM_EN
      .checksum_o(ck_c),
`endif
      .data_out_o(dc));

   // Synchronous ROMs: latency 1 for a/c, latency 3 for b.
   always @(posedge clk) begin
      q_a   <= rom_a[addr_a];
      q_c   <= rom_c[addr_c];
      pb[0] <= rom_b[addr_b];
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign q_b = pb[2];

   int         sel = 0;
   logic       obs_rd, obs_busy, obs_done;
   logic [5:0] obs_addr;
   logic [7:0] obs_ck;

   always_comb begin
      obs_ck = 8'h00;
      case (sel)
         1:       {obs_rd, obs_busy, obs_done, obs_addr} = {rd_b, busy_b, done_b, addr_b};
         2:       {obs_rd, obs_busy, obs_done, obs_addr} = {rd_c, busy_c, done_c, addr_c};
         default: {obs_rd, obs_busy, obs_done, obs_addr} = {rd_a, busy_a, done_a, addr_a};
      endcase
`ifdef ROM_LOADER_CKSUM_EN
      case (sel)
         1:       obs_ck = ck_b;
         2:       obs_ck = ck_c;
         default: obs_ck = ck_a;
      endcase
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int dep_of(input int w);
      return (w == 0) ? 32 : (w == 1) ? 8 : 4;
   endfunction
   function automatic int lat_of(input int w);
      return (w == 1) ? 3 : 1;
   endfunction
   function automatic int base_of(input int w);
      return (w == 1) ? 16 : 0;
   endfunction

   function automatic logic [7:0] model_word(input int w, input int k);
      case (w)
         1:       return rom_b[base_of(w) + k];
         2:       return rom_c[base_of(w) + k];
         default: return rom_a[base_of(w) + k];
      endcase
   endfunction

   function automatic logic [7:0] dut_word(input int w, input int k);
      case (w)
         1:       return db[k];
         2:       return dc[k];
         default: return da[k];
      endcase
   endfunction

   function automatic int nonzero_a();
      int n = 0;
      for (int k = 0; k < 32; k++) if (da[k] !== 8'h00) n++;
      return n;
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       start_b = v;
         2:       start_c = v;
         default: start_a = v;
      endcase
   endtask

   task automatic fill_rom(input int w, input int mode);
      logic [7:0] v;
      for (int a = 0; a < 64; a++) begin
         case (mode)
            0:       v = 8'(a) ^ 8'hA5;
            1:       v = ~8'(a);
            default: v = 8'($urandom);
         endcase
         case (w)
            1:       rom_b[a] = v;
            2:       rom_c[a] = v;
            default: rom_a[a] = v;
         endcase
      end
   endtask

   // Runs one burst from a negedge; edge 0 is the first posedge. Returns at the negedge after done.
   task automatic run_burst(input int w, input int ign, input bit hold);
      int         dep, lat, base, n_rd, done_e, busy_bad;
      bit         addr_ok;
      logic [7:0] sum;
      dep = dep_of(w); lat = lat_of(w); base = base_of(w);
      sel = w;
      n_rd = 0; done_e = -1; busy_bad = 0; addr_ok = 1'b1;
      set_start(w, 1'b1);
      for (int e = 0; e < 200 && done_e < 0; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (!hold) set_start(w, (e + 1 == ign));
         if (obs_rd) begin
            if (obs_addr !== 6'(base + n_rd) || e != n_rd) addr_ok = 1'b0;
            n_rd++;
         end
         if (obs_done) done_e = e;
         else if (!obs_busy) busy_bad++;
      end
      chk($sformatf("done_edge[%0d]", w), done_e, dep + lat + 1);
      chk($sformatf("rd_en_cycles[%0d]", w), n_rd, dep);
      chk($sformatf("addr_seq[%0d]", w), {31'd0, addr_ok}, 1);
      chk($sformatf("busy_profile[%0d]", w), busy_bad, 0);
      chk($sformatf("busy_at_done[%0d]", w), {31'd0, obs_busy}, 0);
      sum = 8'h00;
      for (int k = 0; k < dep; k++) begin
         chk($sformatf("data[%0d][%0d]", w, k), dut_word(w, k), model_word(w, k));
         sum += model_word(w, k);
      end
`ifdef ROM_LOADER_CKSUM_EN
      chk($sformatf("checksum[%0d]", w), obs_ck, sum);
`endif
   endtask

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      fill_rom(0, 0); fill_rom(1, 0); fill_rom(2, 2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("reset_addr_a", addr_a, 0);
      chk("reset_addr_b", addr_b, 16);
      chk("reset_rd_en", {rd_a, rd_b, rd_c}, 0);
      chk("reset_busy", {busy_a, busy_b, busy_c}, 0);
      chk("reset_done", {done_a, done_b, done_c}, 0);
      chk("reset_data_a", nonzero_a(), 0);
`ifdef ROM_LOADER_CKSUM_EN
      chk("reset_cksum", {ck_a, ck_b, ck_c}, 0);
`endif

      // Default burst, then a stray start at edge 10 that must be ignored.
      run_burst(0, -1, 1'b0);
      fill_rom(0, 2);
      run_burst(0, 10, 1'b0);

      // Reload from DONE with inverted contents, then back-to-back bursts with start held.
      fill_rom(0, 1);
      run_burst(0, -1, 1'b0);
      fill_rom(0, 2);
      run_burst(0, -1, 1'b1);
      fill_rom(0, 2);
      run_burst(0, -1, 1'b0);

      // Longer latency, offset base; then random contents.
      run_burst(1, -1, 1'b0);
      fill_rom(1, 2);
      run_burst(1, 4, 1'b0);

      // Small depth: the 1+2+3+250 burst wraps the sum to zero; then random.
      rom_c[0] = 8'd1; rom_c[1] = 8'd2; rom_c[2] = 8'd3; rom_c[3] = 8'd250;
      run_burst(2, -1, 1'b0);
      fill_rom(2, 2);
      run_burst(2, -1, 1'b0);

      // Reset sampled at edge 15 of a burst aborts it and clears everything.
      fill_rom(0, 2);
      sel = 0;
      set_start(0, 1'b1);
      for (int e = 0; e < 15; e++) begin
         @(posedge clk);
         @(negedge clk);
         start_a = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", busy_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_rd_en", rd_a, 0);
      chk("midrst_addr", addr_a, 0);
      chk("midrst_data", nonzero_a(), 0);
      repeat (4) @(negedge clk);
      chk("midrst_late_q", nonzero_a(), 0);
      chk("midrst_idle_busy", busy_a, 0);
      run_burst(0, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
